// File: rtl/fm_coord_ctrl.sv
// rtl/fm_coord_ctrl.sv - output feature-map coordinate sequencer with valid pipeline
module fm_coord_ctrl #(
  parameter int X_BITS   = 5,
  parameter int Y_BITS   = 5,
  parameter int SR_DEPTH = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [X_BITS-1:0] cfg_x_last,
  input  logic [Y_BITS-1:0] cfg_y_last,
  input  logic              stall,
  output logic [X_BITS-1:0] x_coord,
  output logic [Y_BITS-1:0] y_coord,
  output logic              coord_valid,
  output logic              row_end,
  output logic              fm_coord_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  // DRAIN lasts SR_DEPTH-1 cycles, so the counter walks 0 .. SR_DEPTH-2.
  localparam int CNT_BITS = (SR_DEPTH > 2) ? $clog2(SR_DEPTH - 1) : 1;
  localparam logic [CNT_BITS-1:0] DRAIN_LAST = CNT_BITS'((SR_DEPTH > 1) ? SR_DEPTH - 2 : 0);

  state_t              state;
  state_t              state_nxt;
  logic [X_BITS-1:0]   x_last_q;
  logic [Y_BITS-1:0]   y_last_q;
  logic [CNT_BITS-1:0] drain_cnt;
  logic [SR_DEPTH-1:0] vpipe;
  logic                at_x_last;
  logic                last_issue;

  assign at_x_last = (x_coord == x_last_q);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and issue/status outputs
  always_comb begin
    state_nxt   = state;
    coord_valid = 1'b0;
    row_end     = 1'b0;
    last_issue  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        busy        = 1'b1;
        coord_valid = ~stall;
        row_end     = coord_valid & at_x_last;
        last_issue  = coord_valid & at_x_last & (y_coord == y_last_q);
        if (last_issue) state_nxt = (SR_DEPTH == 1) ? S_DONE : S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == DRAIN_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Pass configuration, captured only when a start is accepted
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_last_q <= '0;
      y_last_q <= '0;
    end else if (state == S_IDLE && start) begin
      x_last_q <= cfg_x_last;
      y_last_q <= cfg_y_last;
    end
  end

  // Raster coordinate counters: x fastest, both cleared at pass start and end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_coord <= '0;
      y_coord <= '0;
    end else if (state == S_IDLE && start) begin
      x_coord <= '0;
      y_coord <= '0;
    end else if (coord_valid) begin
      if (last_issue) begin
        x_coord <= '0;
        y_coord <= '0;
      end else if (!at_x_last) begin
        x_coord <= x_coord + 1'b1;
      end else begin
        x_coord <= '0;
        y_coord <= y_coord + 1'b1;
      end
    end
  end

  // Drain counter runs only while in DRAIN, otherwise parked at zero
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                drain_cnt <= '0;
    else if (state == S_DRAIN) drain_cnt <= drain_cnt + 1'b1;
    else                       drain_cnt <= '0;
  end

  // Valid delay line shifts every cycle, mirroring the coordinate shift register
  if (SR_DEPTH == 1) begin : g_pipe_single
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) vpipe <= '0;
      else        vpipe <= coord_valid;
    end
  end else begin : g_pipe_multi
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) vpipe <= '0;
      else        vpipe <= {vpipe[SR_DEPTH-2:0], coord_valid};
    end
  end

  assign fm_coord_valid = vpipe[SR_DEPTH-1];

endmodule

// File: tb/tb_fm_coord_ctrl.sv
// tb/tb_fm_coord_ctrl.sv - directed self-checking bench for fm_coord_ctrl
module tb_fm_coord_ctrl;

  localparam int SR = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       start1;
  logic [4:0] cfg_x_last;
  logic [4:0] cfg_y_last;
  logic       stall;

  logic [4:0] x_coord, y_coord;
  logic       coord_valid, row_end, fm_coord_valid, busy, done;
  logic [4:0] x1, y1;
  logic       cv1, re1, fm1, busy1, done1;

  int checks = 0;
  int fails  = 0;

  fm_coord_ctrl #(.X_BITS(5), .Y_BITS(5), .SR_DEPTH(SR)) dut (
    .clock(clock), .reset(reset), .start(start),
    .cfg_x_last(cfg_x_last), .cfg_y_last(cfg_y_last), .stall(stall),
    .x_coord(x_coord), .y_coord(y_coord), .coord_valid(coord_valid),
    .row_end(row_end), .fm_coord_valid(fm_coord_valid), .busy(busy), .done(done)
  );

  fm_coord_ctrl #(.X_BITS(5), .Y_BITS(5), .SR_DEPTH(1)) dut1 (
    .clock(clock), .reset(reset), .start(start1),
    .cfg_x_last(cfg_x_last), .cfg_y_last(cfg_y_last), .stall(stall),
    .x_coord(x1), .y_coord(y1), .coord_valid(cv1),
    .row_end(re1), .fm_coord_valid(fm1), .busy(busy1), .done(done1)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full pass on the SR=8 instance; expected values come from the issue index.
  task automatic run_pass(input int xl, input int yl, input int stall_at,
                          input int stall_len, input bit poke);
    int total;
    int issued;
    int stalled;
    int t_last;
    int obs_iss;
    int obs_done;
    int xe;
    int ye;
    bit cv_e;
    bit hist[256];
    total    = (xl + 1) * (yl + 1);
    issued   = 0;
    stalled  = 0;
    t_last   = -1;
    obs_iss  = 0;
    obs_done = 0;
    @(negedge clock);
    start      = 1'b1;
    cfg_x_last = 5'(xl);
    cfg_y_last = 5'(yl);
    stall      = 1'b0;
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_cv", coord_valid, 0);
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      start = 1'b0;
      stall = (issued == stall_at) && (stalled < stall_len);
      if (stall) stalled++;
      if (poke && t_last >= 0 && c > t_last) stall = 1'b1;
      if (poke && (c == 2 || (t_last >= 0 && c == t_last + 3))) begin
        start      = 1'b1;
        cfg_x_last = 5'd7;
        cfg_y_last = 5'd1;
      end
      #1;
      cv_e    = (issued < total) && !(issued == stall_at && stall);
      hist[c] = cv_e;
      xe = (issued < total) ? issued % (xl + 1) : 0;
      ye = (issued < total) ? issued / (xl + 1) : 0;
      chk("coord_valid", coord_valid, cv_e);
      chk("x_coord", x_coord, xe);
      chk("y_coord", y_coord, ye);
      chk("row_end", row_end, cv_e && (xe == xl));
      if (cv_e && issued == total - 1) t_last = c;
      chk("fm_coord_valid", fm_coord_valid, (c >= SR) ? hist[c-SR] : 1'b0);
      chk("done", done, (t_last >= 0) && (c == t_last + SR));
      chk("busy", busy, !((t_last >= 0) && (c >= t_last + SR)));
      obs_iss  += int'(coord_valid);
      obs_done += int'(done);
      if (cv_e) issued++;
      if (t_last >= 0 && c == t_last + SR + 1) break;
    end
    stall = 1'b0;
    start = 1'b0;
    chk("issue_count", obs_iss, total);
    chk("done_count", obs_done, 1);
  endtask

  initial begin
    reset      = 1'b0;
    start      = 1'b0;
    start1     = 1'b0;
    cfg_x_last = '0;
    cfg_y_last = '0;
    stall      = 1'b0;

    // Reset values
    @(negedge clock); #1;
    chk("rst_cv", coord_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_fm", fm_coord_valid, 0);
    chk("rst_x", x_coord, 0);
    chk("rst1_busy", busy1, 0);
    @(negedge clock);
    reset = 1'b1;

    // Basic 4x3, stall mid-row, stall on last, start while busy
    run_pass(3, 2, -1, 0, 1'b0);
    run_pass(3, 2, 6, 5, 1'b0);
    run_pass(3, 2, 11, 3, 1'b0);
    run_pass(3, 2, -1, 0, 1'b1);

    // Reset mid-run at (3,1)
    @(negedge clock);
    start      = 1'b1;
    cfg_x_last = 5'd3;
    cfg_y_last = 5'd2;
    for (int i = 0; i < 7; i++) begin
      @(negedge clock);
      start = 1'b0;
    end
    @(negedge clock); #1;
    chk("pre_rst_x", x_coord, 3);
    chk("pre_rst_y", y_coord, 1);
    chk("pre_rst_cv", coord_valid, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_x", x_coord, 0);
    chk("mid_rst_y", y_coord, 0);
    chk("mid_rst_cv", coord_valid, 0);
    chk("mid_rst_re", row_end, 0);
    chk("mid_rst_fm", fm_coord_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clock); #1;
      chk("rst_hold_done", done, 0);
      chk("rst_hold_busy", busy, 0);
    end
    @(negedge clock);
    reset = 1'b1;
    run_pass(3, 2, -1, 0, 1'b0);

    // Degenerate sizes on the SR=8 instance
    run_pass(0, 2, -1, 0, 1'b0);
    run_pass(0, 0, -1, 0, 1'b0);

    // Single coordinate on the SR=1 instance
    @(negedge clock);
    start1     = 1'b1;
    cfg_x_last = 5'd0;
    cfg_y_last = 5'd0;
    #1;
    chk("d1_idle_cv", cv1, 0);
    @(negedge clock);
    start1 = 1'b0;
    #1;
    chk("d1_cv", cv1, 1);
    chk("d1_x", x1, 0);
    chk("d1_y", y1, 0);
    chk("d1_row_end", re1, 1);
    chk("d1_fm_early", fm1, 0);
    chk("d1_busy", busy1, 1);
    chk("d1_done_early", done1, 0);
    @(negedge clock); #1;
    chk("d1_cv_after", cv1, 0);
    chk("d1_fm", fm1, 1);
    chk("d1_done", done1, 1);
    chk("d1_busy_fall", busy1, 0);
    @(negedge clock); #1;
    chk("d1_done_clear", done1, 0);
    chk("d1_fm_clear", fm1, 0);
    chk("d1_busy_idle", busy1, 0);
    start1 = 1'b1;
    @(negedge clock);
    start1 = 1'b0;
    #1;
    chk("d1_restart_cv", cv1, 1);
    repeat (3) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/fm_coord_ctrl.md
# fm_coord_ctrl

Sequencer that walks the output feature-map coordinate space (x fastest, then y) for one convolution pass. It drives the x/y coordinates consumed by the multiplier-adder datapath and by the feature-map coordinate shift register. It also generates a matching valid pipeline and row-end flag, so that the write-back logic knows which delayed coordinates carry real results. It sits between the layer controller (start/config/done) and the multiplier-adder control.

## Interface
Parameters:
- X_BITS, 5, width of x coordinate (X_COORD_BITWIDTH+1)
- Y_BITS, 5, width of y coordinate (Y_COORD_BITWIDTH+1)
- SR_DEPTH, 8, delay in cycles of the coordinate shift register (FM_COORD_SR_DEPTH); legal range is ≥1

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- start  in  1  single-cycle request to begin a pass; honoured only in IDLE
- cfg_x_last  in  X_BITS  last x index (columns−1); sampled on an accepted start
- cfg_y_last  in  Y_BITS  last y index (rows−1); sampled on an accepted start
- stall  in  1  datapath not ready; freezes coordinate advance
- x_coord  out  X_BITS  current x coordinate, registered
- y_coord  out  Y_BITS  current y coordinate, registered
- coord_valid  out  1  x_coord/y_coord are issued this cycle
- row_end  out  1  issued coordinate is the last of its row (x == x_last)
- fm_coord_valid  out  1  coord_valid delayed SR_DEPTH cycles; aligns with shift-register output
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at end of pass

## Operation
- The FSM has four states: IDLE, RUN, DRAIN and DONE.
- **IDLE:**
  - start=1 latches cfg_x_last and cfg_y_last into internal registers.
  - x and y clear to 0, and the FSM moves to RUN.
  - A start in any other state is ignored, and the config inputs are not resampled.
- **RUN:**
  - coord_valid = ~stall. This is combinational from state and stall; coord_valid is 0 outside RUN.
  - On each edge with coord_valid=1:
    - if x ≠ x_last: x ← x+1;
    - else x ← 0 and y ← y+1.
  - With stall=1, x and y hold.
  - Issuing (x_last, y_last) ends the pass. Next state is DRAIN, or DONE when SR_DEPTH=1. x and y return to 0.
- row_end = coord_valid & (x_coord == x_last).
- **DRAIN:**
  - Counts SR_DEPTH−1 cycles and ignores stall.
  - It then moves to DONE.
- **DONE:**
  - done=1 for one cycle, then the FSM returns to IDLE.
- **Valid pipeline:**
  - fm_coord_valid comes from an SR_DEPTH-stage register chain fed by coord_valid.
  - The chain shifts every cycle regardless of stall or state, matching the unconditional coordinate shift register.
- **Pass size:** a pass issues exactly (x_last+1)·(y_last+1) coordinates, each exactly once, in raster order.
- **Widths:** counters never exceed x_last/y_last, so no overflow or wrap beyond the configured range occurs.
- **Degenerate sizes:**
  - x_last=0: every issued coordinate has row_end=1.
  - x_last=y_last=0: a single coordinate is issued.

## Timing
- **Reset** (asynchronous, any state):
  - state = IDLE; x_coord, y_coord, all valid-pipe stages and the drain counter = 0.
  - Outputs: coord_valid, row_end, fm_coord_valid, busy and done = 0.
  - A reset mid-pass abandons the pass, with no done pulse.
- **Start latency:** start sampled at edge E. The first coordinate (0,0) is valid in the cycle after E, if stall=0.
- **Unstalled throughput:** one coordinate per cycle.
- **Valid alignment:** a coordinate issued in cycle t gives fm_coord_valid=1 in cycle t+SR_DEPTH.
- **done timing:**
  - done=1 in cycle t_last+SR_DEPTH, coincident with the last fm_coord_valid.
  - busy falls in that same cycle.
  - Earliest next accepted start: the cycle after done.
- **Stall:**
  - A stall on the last coordinate delays the RUN→DRAIN exit until that coordinate is issued.
  - stall has no effect outside RUN.

## Test plan
- **Reset values:** assert reset mid-RUN (x=3, y=1).
  - Required: all outputs 0 in the same cycle; no done.
  - After release, a start produces a clean pass from (0,0).
- **Basic 4×3 pass:** x_last=3, y_last=2, SR_DEPTH=8, no stall.
  - Required: 12 consecutive coord_valid cycles in raster order (0,0)…(3,2); row_end on x=3 (3 pulses).
  - fm_coord_valid equals coord_valid shifted 8 cycles.
  - done one cycle, 8 cycles after (3,2) was issued.
- **Stall mid-row:** 4×3 pass with stall high for 5 cycles while x=2, y=1.
  - Required: coord_valid=0 and x/y held at (2,1) for those 5 cycles, then resumption at (2,1).
  - Still exactly 12 issues; done delayed by 5 cycles.
- **Stall on last coordinate:** 4×3 pass with stall high for 3 cycles while x=3, y=2.
  - Required: busy stays high, DRAIN not entered until (3,2) issues, then done 8 cycles later.
- **Start while busy:** pulse start with different cfg (x_last=7) during RUN and again during DRAIN.
  - Required: ignored; the pass completes with the original 4×3 size; no second done.
- **Degenerate sizes:** x_last=0, y_last=0, and SR_DEPTH=1 build.
  - Required: one coordinate (0,0) with row_end=1; fm_coord_valid the next cycle; done coincident with it; back to IDLE after.
